serv_mem_seq: RTL and testbench

Sequencer for the load/store/shift buffer register of the bit-serial core. Accepts one operation (load, store or shift) from the decode/state logic and generates the buffer register's control strobes:
- `o_en`, `o_init`, `o_cnt7`, `o_cnt_done`, `o_bytecnt`, `o_load`

It also runs the single-beat Wishbone data-bus transaction and reports completion or trap. It sits between the core state logic and the buffer register plus data bus.

---
 rtl/serv_mem_seq_pkg.sv | 27 ++
 rtl/serv_mem_seq_cnt.sv | 30 +++
 rtl/serv_mem_seq.sv | 114 +++++++++++
 tb/tb_serv_mem_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serv_mem_seq_pkg.sv
// serv_mem_seq_pkg: shared state, operation and size codes plus lane-select helper for the memory sequencer
package serv_mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BUS,
        S_SHIFT,
        S_RUN,
        S_TRAP
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [3:0] wb_sel(input logic [1:0] size, input logic [1:0] lsb);
        return (size >= SZ_WORD) ? 4'b1111 :
               (size == SZ_HALF) ? 4'b0011 << lsb :
                                   4'b0001 << lsb;
    endfunction

endpackage

// File: rtl/serv_mem_seq_cnt.sv
// serv_mem_seq_cnt: 5-bit bit counter with byte-end, pass-end and byte-index decode
module serv_mem_seq_cnt #(
    parameter int W = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic       o_cnt7,
    output logic       o_cnt_done,
    output logic [1:0] o_bytecnt
);

    logic [4:0] cnt;

    // Cleared on entry to a counting phase, then steps by W each active cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (i_clr)
            cnt <= '0;
        else if (i_adv)
            cnt <= cnt + 5'(W);
    end

    assign o_cnt7     = cnt[2:0] == 3'(8 - W);
    assign o_cnt_done = cnt == 5'(32 - W);
    assign o_bytecnt  = cnt[4:3];

endmodule

// File: rtl/serv_mem_seq.sv
// serv_mem_seq: load/store/shift sequencer and single-beat bus master; SERV_MEM_SEQ_TIMEOUT_EN adds a bus timeout trap
module serv_mem_seq
    import serv_mem_seq_pkg::*;
#(
    parameter int W    = 1,
    parameter int TO_W = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [1:0] i_op,
    input  logic [1:0] i_size,
    input  logic [1:0] i_lsb,
    input  logic       i_sh_done,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_trap,
    output logic       o_en,
    output logic       o_init,
    output logic       o_cnt7,
    output logic       o_cnt_done,
    output logic [1:0] o_bytecnt,
    output logic [1:0] o_lsb,
    output logic       o_shift_op,
    output logic       o_load,
    output logic       o_wb_cyc,
    output logic       o_wb_we,
    output logic [3:0] o_wb_sel,
    input  logic       i_wb_ack
);

    state_t     state, state_n;
    logic [1:0] op_q, size_q, lsb_q;
    logic       is_load, is_store, is_shift, misaligned, ack, to_exp, cnt_clr;

    assign is_load    = op_q == OP_LOAD;
    assign is_store   = op_q == OP_STORE;
    assign is_shift   = op_q >= OP_SHIFT;
    assign misaligned = (i_op < OP_SHIFT) &&
                        ((i_size >= SZ_WORD && i_lsb != 2'b00) ||
                         (i_size == SZ_HALF && i_lsb == 2'b11));
    assign ack        = state == S_BUS && i_wb_ack;

    // State register; request fields only change on an accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            size_q <= '0;
            lsb_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && i_go) begin
                op_q   <= i_op;
                size_q <= i_size;
                lsb_q  <= i_lsb;
            end
        end
    end

    // Next-state: an ack in the timeout expiry cycle takes priority over the trap
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_go) state_n = misaligned ? S_TRAP : S_INIT;
            S_INIT:  if (o_cnt_done) state_n = is_shift ? S_SHIFT : S_BUS;
            S_BUS:   state_n = i_wb_ack ? (is_load ? S_RUN : S_IDLE) : (to_exp ? S_TRAP : S_BUS);
            S_SHIFT: if (i_sh_done) state_n = S_RUN;
            S_RUN:   if (o_cnt_done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

`ifdef SERV_MEM_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent waiting in BUS; idle value is zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            to_cnt <= '0;
        else
            to_cnt <= (state == S_BUS) ? to_cnt + 1'b1 : '0;
    end

    assign to_exp = &to_cnt;
`else
    assign to_exp = TO_W < 0;
`endif

    assign cnt_clr = state_n != state && (state_n == S_INIT || state_n == S_RUN);

    serv_mem_seq_cnt #(.W(W)) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (cnt_clr),
        .i_adv      (o_en),
        .o_cnt7     (o_cnt7),
        .o_cnt_done (o_cnt_done),
        .o_bytecnt  (o_bytecnt)
    );

    assign o_busy     = state != S_IDLE;
    assign o_en       = state == S_INIT || state == S_RUN;
    assign o_init     = state == S_INIT;
    assign o_trap     = state == S_TRAP;
    assign o_wb_cyc   = state == S_BUS;
    assign o_wb_we    = o_wb_cyc && is_store;
    assign o_wb_sel   = o_wb_cyc ? wb_sel(size_q, lsb_q) : 4'b0000;
    assign o_load     = ack && is_load;
    assign o_done     = (state == S_RUN && o_cnt_done) || (ack && is_store);
    assign o_lsb      = lsb_q;
    assign o_shift_op = is_shift;

endmodule

// File: tb/tb_serv_mem_seq.sv
// tb_serv_mem_seq: scoreboard bench for serv_mem_seq (timeout cases only with SERV_MEM_SEQ_TIMEOUT_EN)
module tb_serv_mem_seq;

    logic       i_clk = 0, i_rst = 1, i_go = 0, i_sh_done = 0, i_wb_ack = 0;
    logic [1:0] i_op = 0, i_size = 0, i_lsb = 0;
    logic       o_busy, o_done, o_trap, o_en, o_init, o_cnt7, o_cnt_done, o_shift_op, o_load, o_wb_cyc, o_wb_we;
    logic [1:0] o_bytecnt, o_lsb;
    logic [3:0] o_wb_sel;

    typedef struct {
        logic       trap;
        int         lat;
        logic [3:0] sel;
        logic       we;
        int         n_init;
        int         n_run;
        int         n_bus;
        int         n_load;
        int         n_shop;
        logic [1:0] lsb;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, go_cyc = 0, ack_k = -1, sh_k = 0;
    int   a_init, a_run, a_bus, a_load, a_c7, a_sh, a_shop, a_busy, a_bad;
    logic [3:0] a_sel;
    logic       a_we, ended;

    serv_mem_seq #(.W(1), .TO_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_go(i_go), .i_op(i_op), .i_size(i_size), .i_lsb(i_lsb),
        .i_sh_done(i_sh_done), .o_busy(o_busy), .o_done(o_done), .o_trap(o_trap), .o_en(o_en),
        .o_init(o_init), .o_cnt7(o_cnt7), .o_cnt_done(o_cnt_done), .o_bytecnt(o_bytecnt),
        .o_lsb(o_lsb), .o_shift_op(o_shift_op), .o_load(o_load), .o_wb_cyc(o_wb_cyc),
        .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr_acc();
        a_init = 0; a_run = 0; a_bus = 0; a_load = 0; a_c7 = 0; a_sh = 0;
        a_shop = 0; a_busy = 0; a_bad = 0; a_sel = 0; a_we = 0;
    endtask

    function automatic exp_t mk(input logic [1:0] op, input logic [1:0] sz, input logic [1:0] lsb, input int k);
        exp_t e;
        logic mem, mis;
        mem      = op == 2'b00 || op == 2'b01;
        mis      = mem && ((sz[1] && lsb != 2'b00) || (sz == 2'b01 && lsb == 2'b11));
        e.trap   = mis || (mem && k < 0);
        e.lsb    = lsb;
        e.n_init = mis ? 0 : 32;
        e.n_run  = (!mis && op != 2'b01 && k >= 0) ? 32 : 0;
        e.n_bus  = (!mem || mis) ? 0 : (k < 0 ? 16 : k + 1);
        e.n_load = (op == 2'b00 && !mis && k >= 0) ? 1 : 0;
        e.we     = mem && !mis && op == 2'b01;
        if (!mem || mis)    e.sel = 4'b0000;
        else if (sz[1])     e.sel = 4'b1111;
        else if (sz == 2'b01) e.sel = {lsb == 2, lsb == 1 || lsb == 2, lsb <= 1, lsb == 0};
        else                e.sel = {lsb == 3, lsb == 2, lsb == 1, lsb == 0};
        if (mis)            e.lat = 1;
        else if (k < 0)     e.lat = 49;
        else if (op == 2'b01) e.lat = 33 + k;
        else                e.lat = 65 + k;
        e.n_shop = mem ? 0 : e.lat;
        return e;
    endfunction

    // Monitor / bus and shifter responder / scoreboard checker
    initial begin
        exp_t e;
        logic shift_st;
        clr_acc();
        ended = 0;
        forever begin
            @(negedge i_clk);
            shift_st  = o_busy && !o_en && !o_wb_cyc && !o_trap;
            i_wb_ack  = o_wb_cyc && a_bus == ack_k;
            i_sh_done = shift_st && a_sh == sh_k;
            #1;
            if (i_rst) begin
                clr_acc();
                ended = 0;
                continue;
            end
            if (ended) check("pulse_len", {o_done, o_trap}, 0);
            ended = 0;
            if (o_init) begin
                if (o_cnt7) begin
                    check("bytecnt_at_cnt7", o_bytecnt, a_c7);
                    a_c7++;
                end
                a_init++;
            end
            if (o_en && !o_init) a_run++;
            if (o_busy) a_busy++;
            if (o_busy && o_shift_op) a_shop++;
            if (o_wb_cyc) begin
                if (a_bus == 0) begin
                    a_sel = o_wb_sel;
                    a_we  = o_wb_we;
                end else if (o_wb_sel !== a_sel || o_wb_we !== a_we) a_bad++;
                a_bus++;
            end else if (o_wb_sel !== 4'b0000 || o_wb_we !== 1'b0) a_bad++;
            if (o_load) a_load++;
            if (o_load && !i_wb_ack) a_bad++;
            a_sh = shift_st ? a_sh + 1 : 0;
            if (o_done || o_trap) begin
                if (sb.size() == 0) check("unexpected_end", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("trap", o_trap, e.trap);
                    check("done", o_done, !e.trap);
                    check("latency", cyc - go_cyc, e.lat);
                    check("busy_cycles", a_busy, e.lat);
                    check("init_cycles", a_init, e.n_init);
                    check("cnt7_pulses", a_c7, e.n_init / 8);
                    check("run_cycles", a_run, e.n_run);
                    check("bus_cycles", a_bus, e.n_bus);
                    check("wb_sel", a_sel, e.sel);
                    check("wb_we", a_we, e.we);
                    check("load_pulses", a_load, e.n_load);
                    check("shift_op_cycles", a_shop, e.n_shop);
                    check("lsb_latched", o_lsb, e.lsb);
                    check("bus_protocol", a_bad, 0);
                end
                clr_acc();
                ended = 1;
            end
        end
    end

    // Issue one request, push its expectation, then wait for it with go noise while busy
    task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic [1:0] lsb, input int k);
        @(negedge i_clk);
        ack_k  = (op[1] ? -1 : k);
        sh_k   = (op[1] ? k : 0);
        i_op   = op;
        i_size = sz;
        i_lsb  = lsb;
        i_go   = 1;
        go_cyc = cyc;
        sb.push_back(mk(op, sz, lsb, k));
        @(negedge i_clk);
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin
            i_go   = 1'($urandom_range(0, 1));
            i_op   = 2'($urandom_range(0, 3));
            i_size = 2'($urandom_range(0, 3));
            i_lsb  = 2'($urandom_range(0, 3));
            @(negedge i_clk);
        end
        i_go = 0;
        check("op_complete", sb.size(), 0);
        sb.delete();
        @(negedge i_clk);
    endtask

    initial begin
        #12;
        check("rst_busy", o_busy, 0);
        check("rst_outputs", {o_done, o_trap, o_en, o_init, o_load, o_wb_cyc, o_wb_we, o_shift_op}, 0);
        check("rst_sel", o_wb_sel, 0);
        check("rst_bytecnt_lsb", {o_bytecnt, o_lsb}, 0);
        @(negedge i_clk);
        i_rst = 0;
        run_op(2'b00, 2'b10, 2'b00, 3);
        run_op(2'b01, 2'b00, 2'b10, 1);
        run_op(2'b00, 2'b01, 2'b11, 0);
        run_op(2'b01, 2'b10, 2'b01, 0);
        run_op(2'b10, 2'b00, 2'b00, 5);
        run_op(2'b00, 2'b00, 2'b11, 0);
        run_op(2'b01, 2'b01, 2'b10, 2);
        run_op(2'b00, 2'b01, 2'b01, 0);
        run_op(2'b11, 2'b10, 2'b11, 0);
        // reset while the bus cycle is open
        @(negedge i_clk);
        ack_k  = -1;
        i_op   = 2'b00;
        i_size = 2'b10;
        i_lsb  = 2'b00;
        i_go   = 1;
        @(negedge i_clk);
        i_go = 0;
        for (int t = 0; t < 100 && !o_wb_cyc; t++) @(negedge i_clk);
        check("rst_reach_bus", o_wb_cyc, 1);
        @(posedge i_clk);
        #2;
        i_rst = 1;
        #1;
        check("rst_async_cyc", o_wb_cyc, 0);
        check("rst_async_busy", o_busy, 0);
        check("rst_async_bytecnt", o_bytecnt, 0);
        @(negedge i_clk);
        #2;
        i_rst = 0;
        run_op(2'b00, 2'b10, 2'b00, 0);
`ifdef SERV_MEM_SEQ_TIMEOUT_EN
        run_op(2'b00, 2'b10, 2'b00, -1);
        run_op(2'b01, 2'b10, 2'b00, 15);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
